// File: rtl/pcm_feed_scheduler_if.sv
// -----------------------------------------------------------------------------
// pcm_feed_scheduler_if
//
// Bundles the two streaming handshakes around the PCM feed scheduler:
//   source side    : in_sample / in_valid  (to scheduler), in_ready (from it)
//   modulator side : mod_sample / mod_valid (from scheduler), mod_ready (to it)
//
// Modports:
//   slave  - the scheduler itself (consumes source data, drives the modulator)
//   master - the environment (PCM source plus modulator consumption strobe)
// -----------------------------------------------------------------------------
interface pcm_feed_scheduler_if #(
   parameter int SAMPLE_WIDTH = 24
);

   logic [SAMPLE_WIDTH-1:0] in_sample;
   logic                    in_valid;
   logic                    in_ready;
   logic [SAMPLE_WIDTH-1:0] mod_sample;
   logic                    mod_valid;
   logic                    mod_ready;

   modport master (
      output in_sample,
      output in_valid,
      output mod_ready,
      input  in_ready,
      input  mod_sample,
      input  mod_valid
   );

   modport slave (
      input  in_sample,
      input  in_valid,
      input  mod_ready,
      output in_ready,
      output mod_sample,
      output mod_valid
   );

endinterface

// File: rtl/pcm_feed_scheduler.sv
// -----------------------------------------------------------------------------
// pcm_feed_scheduler
//
// Feeds signed PCM into the delta-sigma modulator. Incoming samples are
// buffered in a small FIFO; playback starts once the FIFO reaches a prefill
// level. One sample is handed over per modulator consumption strobe, scaled by
// a linear gain ramp that fades in on start and fades out on stop so that the
// modulator never sees a step. Strobes that find the FIFO empty while playing
// are counted as underruns.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   enable          - level: 1 = play, 0 = stop with fade-out
//   bus (slave)     - in_sample/in_valid/in_ready from the source,
//                     mod_sample/mod_valid/mod_ready to the modulator
//   state           - 0 IDLE, 1 PREFILL, 2 RUN, 3 FADE
//   fifo_level      - current FIFO occupancy
//   underrun_count  - saturating count of empty-FIFO strobes in RUN
// -----------------------------------------------------------------------------
module pcm_feed_scheduler #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int FIFO_DEPTH   = 16,
   parameter int PREFILL      = 8,
   parameter int RAMP_STEPS   = 64,
   localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   pcm_feed_scheduler_if.slave    bus,
   output logic [1:0]             state,
   output logic [LEVEL_WIDTH-1:0] fifo_level,
   output logic [15:0]            underrun_count
);

   localparam int ADDR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int RAMP_LOG2  = $clog2(RAMP_STEPS);
   localparam int GAIN_WIDTH = RAMP_LOG2 + 1;
   localparam int PROD_WIDTH = SAMPLE_WIDTH + RAMP_LOG2 + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREFILL = 2'd1,
      ST_RUN     = 2'd2,
      ST_FADE    = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
   logic [LEVEL_WIDTH-1:0]   level_q, level_d;
   logic [GAIN_WIDTH-1:0]    gain_q, gain_d;
   logic [SAMPLE_WIDTH-1:0]  mod_sample_q, mod_sample_d;
   logic                     mod_valid_q;
   logic [15:0]              underrun_q, underrun_d;
   logic [SAMPLE_WIDTH-1:0]  mem_q [FIFO_DEPTH];

   logic                     full;
   logic                     not_empty;
   logic                     in_ready;
   logic                     push;
   logic                     pop;
   logic                     flush;
   logic [GAIN_WIDTH-1:0]    gain_next;
   logic [SAMPLE_WIDTH-1:0]  scale_in;
   logic signed [PROD_WIDTH-1:0] head_ext;
   logic signed [PROD_WIDTH-1:0] gain_ext;
   logic [SAMPLE_WIDTH-1:0]  scaled;

   // Acceptance is decoded from the registered level only, so a full FIFO
   // refuses a push even in a cycle where it also pops.
   always_comb begin
      full      = (level_q == LEVEL_WIDTH'(FIFO_DEPTH));
      not_empty = (level_q != '0);
      in_ready  = (state_q != ST_IDLE) && !full;
      push      = bus.in_valid && in_ready;
   end

   // Gain the next strobe would apply: climbing and clamped at unity while
   // playing, falling and clamped at zero while fading. An empty FIFO during
   // a fade feeds silence through the same scaling path.
   always_comb begin
      gain_next = gain_q;
      if (state_q == ST_RUN) begin
         if (gain_q != GAIN_WIDTH'(RAMP_STEPS)) begin
            gain_next = gain_q + GAIN_WIDTH'(1);
         end
      end else if (gain_q != '0) begin
         gain_next = gain_q - GAIN_WIDTH'(1);
      end
      scale_in = not_empty ? mem_q[rd_ptr_q] : '0;
   end

   // Signed sample times unsigned gain, arithmetic shift (floor) by the ramp
   // length. Gain equal to RAMP_STEPS is exact unity, so the truncation back
   // to the sample width never loses significant bits.
   assign head_ext = {{(RAMP_LOG2 + 1){scale_in[SAMPLE_WIDTH-1]}}, scale_in};
   assign gain_ext = {{SAMPLE_WIDTH{1'b0}}, gain_next};
   assign scaled   = SAMPLE_WIDTH'((head_ext * gain_ext) >>> RAMP_LOG2);

   // Sequencing: a strobe is always handled under the state it arrives in,
   // and any state change decided in the same cycle lands on the same edge.
   // Returning to IDLE discards whatever is still buffered.
   always_comb begin
      state_d      = state_q;
      gain_d       = gain_q;
      mod_sample_d = mod_sample_q;
      underrun_d   = underrun_q;
      pop          = 1'b0;
      flush        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_PREFILL;
            end
         end

         ST_PREFILL: begin
            if (!enable) begin
               state_d = ST_IDLE;
               flush   = 1'b1;
            end else if (level_q >= LEVEL_WIDTH'(PREFILL)) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (bus.mod_ready) begin
               gain_d = gain_next;
               if (not_empty) begin
                  pop          = 1'b1;
                  mod_sample_d = scaled;
               end else begin
                  mod_sample_d = '0;
                  if (underrun_q != 16'hFFFF) begin
                     underrun_d = underrun_q + 16'd1;
                  end
               end
            end
            if (!enable) begin
               state_d = ST_FADE;
            end
         end

         ST_FADE: begin
            if (bus.mod_ready) begin
               gain_d       = gain_next;
               pop          = not_empty;
               mod_sample_d = scaled;
            end
            // Completing the fade wins over a simultaneous re-enable; the
            // source then restarts through PREFILL.
            if (bus.mod_ready && (gain_next == '0)) begin
               state_d = ST_IDLE;
               flush   = 1'b1;
            end else if (enable) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_IDLE;
            flush   = 1'b1;
         end
      endcase
   end

   // FIFO bookkeeping. A flush overrides any push or pop in the same cycle.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
         end
         if (push && !pop) begin
            level_d = level_q + LEVEL_WIDTH'(1);
         end else if (pop && !push) begin
            level_d = level_q - LEVEL_WIDTH'(1);
         end
      end
   end

   // State and control registers. mod_valid rises on the first edge after
   // reset and stays high from then on.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         level_q      <= '0;
         gain_q       <= '0;
         mod_sample_q <= '0;
         mod_valid_q  <= 1'b0;
         underrun_q   <= '0;
      end else begin
         state_q      <= state_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         level_q      <= level_d;
         gain_q       <= gain_d;
         mod_sample_q <= mod_sample_d;
         mod_valid_q  <= 1'b1;
         underrun_q   <= underrun_d;
      end
   end

   // Sample storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.in_sample;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.mod_sample  = mod_sample_q;
   assign bus.mod_valid   = mod_valid_q;
   assign state           = state_q;
   assign fifo_level      = level_q;
   assign underrun_count  = underrun_q;

endmodule

// File: tb/tb_pcm_feed_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pcm_feed_scheduler
//
// Drives the PCM feed scheduler through reset, prefill, fade-in, underrun,
// fade-out, re-enable and backpressure scenarios, then a long randomized run.
// A queue-based reference model tracks the expected playback state, FIFO
// contents, gain and outputs; every cycle the DUT outputs are compared to it.
// -----------------------------------------------------------------------------
module tb_pcm_feed_scheduler;

   localparam int SW    = 24;
   localparam int DEPTH = 16;
   localparam int PRE   = 8;
   localparam int RS    = 64;
   localparam int C_ONE = 1048576;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [1:0]  state;
   logic [4:0]  fifo_level;
   logic [15:0] underrun_count;

   int checks = 0;
   int errors = 0;

   // Reference model: playback state, buffered samples, gain and outputs.
   int m_state;
   int m_q[$];
   int m_gain;
   int m_ms;
   int m_ur;
   int m_mv;

   pcm_feed_scheduler_if #(.SAMPLE_WIDTH(SW)) bus ();

   pcm_feed_scheduler #(
      .SAMPLE_WIDTH(SW),
      .FIFO_DEPTH  (DEPTH),
      .PREFILL     (PRE),
      .RAMP_STEPS  (RS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .bus           (bus),
      .state         (state),
      .fifo_level    (fifo_level),
      .underrun_count(underrun_count)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Sample times gain over the ramp length, rounded toward minus infinity.
   function automatic int scale(int h, int g);
      longint p;
      p = longint'(h) * longint'(g);
      if (p >= 0) return int'(p / RS);
      return int'(-((-p + RS - 1) / RS));
   endfunction

   function automatic int randSample();
      logic [SW-1:0] r;
      r = SW'($urandom);
      return int'($signed(r));
   endfunction

   task automatic checkValue(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Compares every observable output against the model.
   task automatic checkOutput();
      checkValue("state", {30'd0, state}, m_state);
      checkValue("mod_sample", $signed(bus.mod_sample), m_ms);
      checkValue("fifo_level", {27'd0, fifo_level}, m_q.size());
      checkValue("underrun_count", {16'd0, underrun_count}, m_ur);
      checkValue("mod_valid", {31'd0, bus.mod_valid}, m_mv);
      checkValue("in_ready", {31'd0, bus.in_ready},
                 ((m_state != 0) && (m_q.size() < DEPTH)) ? 1 : 0);
   endtask

   // One clock edge of the behavioural rules, using the inputs that were
   // presented during the cycle.
   task automatic modelStep(input bit en, input bit iv, input int samp, input bit mr);
      int  ns;
      int  g;
      int  h;
      bit  flush;
      bit  acc;
      ns    = m_state;
      flush = 1'b0;
      acc   = iv && (m_state != 0) && (m_q.size() < DEPTH);
      case (m_state)
         0: if (en) ns = 1;
         1: begin
            if (!en) begin
               ns    = 0;
               flush = 1'b1;
            end else if (m_q.size() >= PRE) begin
               ns = 2;
            end
         end
         2: begin
            if (mr) begin
               g = (m_gain < RS) ? m_gain + 1 : RS;
               if (m_q.size() > 0) begin
                  h    = m_q.pop_front();
                  m_ms = scale(h, g);
               end else begin
                  m_ms = 0;
                  if (m_ur < 65535) m_ur++;
               end
               m_gain = g;
            end
            if (!en) ns = 3;
         end
         default: begin
            if (mr) begin
               g = (m_gain > 0) ? m_gain - 1 : 0;
               h = 0;
               if (m_q.size() > 0) h = m_q.pop_front();
               m_ms   = scale(h, g);
               m_gain = g;
               if (g == 0) begin
                  ns    = 0;
                  flush = 1'b1;
               end
            end
            if (ns != 0 && en) ns = 2;
         end
      endcase
      if (acc) m_q.push_back(samp);
      if (flush) m_q.delete();
      m_state = ns;
      m_mv    = 1;
   endtask

   task automatic applyStimulus(input bit en, input bit iv, input int samp, input bit mr);
      enable        = en;
      bus.in_valid  = iv;
      bus.in_sample = SW'(samp);
      bus.mod_ready = mr;
      @(posedge clk);
      modelStep(en, iv, samp, mr);
      #1;
      checkOutput();
   endtask

   task automatic doReset(input int n);
      rst           = 1'b1;
      enable        = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sample = '0;
      bus.mod_ready = 1'b0;
      repeat (n) begin
         @(posedge clk);
         m_state = 0;
         m_q.delete();
         m_gain  = 0;
         m_ms    = 0;
         m_ur    = 0;
         m_mv    = 0;
         #1;
         checkOutput();
      end
      rst = 1'b0;
   endtask

   // Reset, enable, prefill with 'first' followed by seven more samples
   // (copies of 'first' or random), and wait for playback to start.
   task automatic startRun(input int first, input bit constFill);
      doReset(2);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, first, 0);
      for (int i = 1; i < PRE; i++) begin
         applyStimulus(1, 1, constFill ? first : randSample(), 0);
      end
      for (int i = 0; i < 4 && m_state != 2; i++) begin
         applyStimulus(1, 0, 0, 0);
      end
      checkValue("enter_run", {30'd0, state}, 2);
   endtask

   // Bring a fresh run up to unity gain while keeping the FIFO topped up.
   task automatic rampToUnity();
      startRun(randSample(), 1'b0);
      for (int i = 0; i < 200 && m_gain < RS; i++) begin
         applyStimulus(1, 1, randSample(), 1);
      end
      checkValue("unity_state", {30'd0, state}, 2);
   endtask

   initial begin
      bit en;

      // Reset and first cycle after release.
      doReset(2);
      applyStimulus(0, 0, 0, 0);
      checkValue("mod_valid_after_reset", {31'd0, bus.mod_valid}, 1);

      // Prefill: seven samples keep PREFILL, the eighth starts playback.
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < PRE - 1; i++) begin
         applyStimulus(1, 1, randSample(), 0);
      end
      checkValue("prefill_state", {30'd0, state}, 1);
      checkValue("prefill_sample", $signed(bus.mod_sample), 0);
      applyStimulus(1, 1, randSample(), 0);
      applyStimulus(1, 0, 0, 0);
      checkValue("run_after_prefill", {30'd0, state}, 2);

      // Fade-in with a constant input.
      startRun(C_ONE, 1'b1);
      applyStimulus(1, 1, C_ONE, 1);
      checkValue("fadein_first", $signed(bus.mod_sample), 16384);
      for (int i = 2; i <= 65; i++) begin
         applyStimulus(1, 1, C_ONE, 0);
         applyStimulus(1, 1, C_ONE, 1);
         if (i == 64) checkValue("fadein_64", $signed(bus.mod_sample), C_ONE);
         if (i == 65) checkValue("fadein_65", $signed(bus.mod_sample), C_ONE);
      end

      // Floor behaviour of negative samples at gain 1.
      startRun(-1, 1'b0);
      applyStimulus(1, 0, 0, 1);
      checkValue("neg_one_gain1", $signed(bus.mod_sample), -1);
      startRun(-C_ONE, 1'b0);
      applyStimulus(1, 0, 0, 1);
      checkValue("neg_big_gain1", $signed(bus.mod_sample), -16384);

      // Underrun: drain, three empty strobes, then resume feeding.
      for (int i = 0; i < 20 && m_q.size() > 0; i++) begin
         applyStimulus(1, 0, 0, 1);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 1);
         checkValue("underrun_sample", $signed(bus.mod_sample), 0);
      end
      checkValue("underrun_count3", {16'd0, underrun_count}, 3);
      checkValue("underrun_state", {30'd0, state}, 2);
      applyStimulus(1, 1, C_ONE, 0);
      applyStimulus(1, 0, 0, 1);
      checkValue("resume_after_underrun", $signed(bus.mod_sample), scale(C_ONE, m_gain));

      // Full fade-out from unity with the FIFO kept fed.
      rampToUnity();
      applyStimulus(0, 1, randSample(), 0);
      checkValue("fade_state", {30'd0, state}, 3);
      for (int i = 0; i < RS; i++) begin
         applyStimulus(0, 1, randSample(), 1);
      end
      checkValue("fade_end_state", {30'd0, state}, 0);
      checkValue("fade_end_level", {27'd0, fifo_level}, 0);
      checkValue("fade_end_in_ready", {31'd0, bus.in_ready}, 0);
      checkValue("fade_end_sample", $signed(bus.mod_sample), 0);

      // Re-enable partway through a fade, at gain 40.
      rampToUnity();
      applyStimulus(0, 1, randSample(), 0);
      for (int i = 0; i < RS - 40; i++) begin
         applyStimulus(0, 1, randSample(), 1);
      end
      applyStimulus(1, 1, randSample(), 0);
      checkValue("reenable_state", {30'd0, state}, 2);
      applyStimulus(1, 1, randSample(), 1);

      // Backpressure at full depth.
      doReset(2);
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1, 1, randSample(), 0);
      end
      checkValue("full_level", {27'd0, fifo_level}, DEPTH);
      checkValue("full_in_ready", {31'd0, bus.in_ready}, 0);
      applyStimulus(1, 1, randSample(), 1);
      checkValue("pop_level", {27'd0, fifo_level}, DEPTH - 1);
      checkValue("pop_in_ready", {31'd0, bus.in_ready}, 1);
      applyStimulus(1, 1, randSample(), 1);
      checkValue("pushpop_level", {27'd0, fifo_level}, DEPTH - 1);

      // Long randomized run with occasional start/stop.
      en = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 149) == 0) en = ~en;
         applyStimulus(en, ($urandom_range(0, 3) != 0), randSample(),
                       ($urandom_range(0, 2) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
